copro_issue_unit: RTL and testbench
===================================

// Module: copro_issue_unit
// PURPOSE
//  Host-side initiator for the matrix coprocessor control unit. It takes 32-bit command words from the
//  ARM/HPS bridge and assembles operand matrices A and B (200 bits, 25 signed bytes, row-major).
//  It issues the 6-bit instruction with a held start, waits for ready, then captures result and overflow.
//  Result bytes and status are served back to the host. Sits between the HPS PIO bridge and the control unit.
// PARAMETERS
//  TIMEOUT_CYCLES  4096  clk cycles allowed from EXEC accept to return to IDLE before abort
//  CNT_W           13    timeout counter width (must hold TIMEOUT_CYCLES)
// PORTS
//  clk             in   1    single system clock (fast clock; coprocessor runs on its own divided clock)
//  rst_n           in   1    asynchronous, active-low reset
//  cmd_valid       in   1    host command word valid
//  cmd_ready       out  1    command accepted when cmd_valid && cmd_ready
//  cmd_data        in   32   command word, see BEHAVIOUR
//  resp_data       out  32   {done,ovf,timeout,err,4'b0,byte[b],byte[b+1],byte[b+2]}; held until next READ
//  resp_valid      out  1    1-cycle pulse, cycle after READ accept
//  busy            out  1    1 in ISSUE/WAIT/DRAIN
//  matrix_a        out  200  operand A to coprocessor; byte i = bits [199-8i -: 8]
//  matrix_b        out  200  operand B, same layout (MULT_INT scalar = byte 24)
//  instruction     out  6    latched EXEC field
//  start           out  1    issue strobe, level-held (see ISSUE)
//  matrix_result   in   200  coprocessor result
//  copro_ready     in   1    coprocessor result-ready
//  copro_overflow  in   1    coprocessor overflow
//  copro_state     in   3    coprocessor FSM state; 3'b000 = IDLE
// BEHAVIOUR
//  Reset: all outputs, A/B/result regs, flags and counter = 0; FSM = IDLE; cmd_ready = 1 one cycle after release.
//  Command word [31:29]: 000 NOP, 001 LOAD, 010 EXEC, 011 READ, 100 CLEAR; others: set err, no other effect.
//  LOAD: [28] sel (0=A, 1=B), [20:16] base b, [15:8] -> byte b, [7:0] -> byte b+1 (b+1 > 24 dropped).
//        b > 24: nothing written, err = 1.
//  EXEC: [5:0] -> instruction. Opcode [4:2] == 3'b111: err = 1, no issue.
//        Otherwise clear done/ovf/timeout/err, go to ARM.
//  READ: [4:0] base b; bytes from result reg, index > 24 reads 0. Read-only; does not clear flags.
//  CLEAR: zero A, B, result, instruction and all flags.
//  cmd_ready = 1 only in IDLE. No command is accepted while busy.
//  FSM (timeout counter runs in every state except IDLE):
//   IDLE  -> ARM on valid EXEC accept.
//   ARM   -> ISSUE when copro_state == 000. Start stays 0.
//   ISSUE -> WAIT when copro_state != 000. Start = 1 throughout ISSUE, which absorbs the divided-clock sample latency.
//   WAIT  -> DRAIN on first cycle copro_ready == 1.
//            That cycle: result <= matrix_result, ovf <= copro_overflow, done <= 1. Start = 0.
//   DRAIN -> IDLE when copro_state == 000 (coprocessor finished CLN). This prevents a re-trigger on the next EXEC.
//   Counter reaches TIMEOUT_CYCLES in ARM/ISSUE/WAIT/DRAIN: start = 0, timeout = 1, done = 0, result unchanged,
//            -> IDLE.
//  Simultaneous: copro_ready and timeout on the same cycle -> ready wins (capture, go to DRAIN).
//  LOAD while done = 1 is allowed; it does not alter result or flags.
//  Reset mid-operation: immediate return to reset values. start drops asynchronously.
//  Latency: EXEC accept -> start = 1 is 2 clk when the coprocessor is idle.
// STRUCTURE
//  Shared package copro_defs.vh holds:
//   - command codes CMD_NOP/LOAD/EXEC/READ/CLEAR
//   - status bit positions
//   - coprocessor state IDLE = 3'b000 and opcode 3'b111 = invalid
//   - the byte-index to bit-slice macro
//  One sub-module, byte_lane_writer: 200-bit register with two indexed byte-write ports. Instantiated for A and B.
//  FSM, counter and response mux stay in this module.
// TESTING
//  1. Reset: rst_n=0 mid-WAIT -> start=0, busy=0, resp_data=0, A/B=0 immediately. cmd_ready=1 after release.
//  2. LOAD A 13 words (b=0,2,..24, bytes 1..25); b=24 byte1=0x7F -> byte24=25, 0x7F dropped. A[199:192]=1, A[7:0]=25.
//  3. EXEC 6'b000011 (SOMA, 5x5); model asserts state!=0 after 20 clk, ready at 60 -> start high exactly in ISSUE.
//     Result captured, done=1; READ b=0 -> {8'h80, r0, r1, r2}.
//  4. Model pulses copro_ready with overflow=1 -> resp_data[30]=1. Next EXEC clears it.
//  5. Model never responds -> timeout=1 at TIMEOUT_CYCLES after accept, start=0, FSM in IDLE, prior result intact.
//  6. EXEC while model sits in CLN (state=101) -> stays in ARM, start=0 until state=000.
//     LOAD b=30 and cmd 3'b111 -> err=1.

Source files
------------

// File: rtl/copro_issue_unit_pkg.sv
// Shared definitions for the coprocessor issue unit: command codes, status bit
// positions, coprocessor handshake constants and row-major byte addressing.
package copro_issue_unit_pkg;

    localparam int NUM_BYTES = 25;
    localparam int BUS_W     = 200;
    localparam logic [4:0] MAX_IDX = 5'd24;

    localparam logic [2:0] CMD_NOP   = 3'b000;
    localparam logic [2:0] CMD_LOAD  = 3'b001;
    localparam logic [2:0] CMD_EXEC  = 3'b010;
    localparam logic [2:0] CMD_READ  = 3'b011;
    localparam logic [2:0] CMD_CLEAR = 3'b100;

    localparam int RSP_DONE = 31;
    localparam int RSP_OVF  = 30;
    localparam int RSP_TMO  = 29;
    localparam int RSP_ERR  = 28;

    localparam logic [2:0] COPRO_IDLE = 3'b000;
    localparam logic [2:0] OP_INVALID = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    // Byte 0 sits in the most significant lane of the bus.
    function automatic int byte_lsb(input int idx);
        return BUS_W - 8 * (idx + 1);
    endfunction

    function automatic logic [7:0] bus_byte(input logic [BUS_W-1:0] bus, input logic [5:0] idx);
        logic [7:0] val;
        val = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (idx == 6'(i)) val = bus[byte_lsb(i) +: 8];
        end
        return val;
    endfunction

endpackage

// File: rtl/copro_issue_unit_byte_lane_writer.sv
// 25-byte operand register with two independent byte-write ports and a
// synchronous clear; the two ports never target the same lane in practice.
module byte_lane_writer import copro_issue_unit_pkg::*; (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             wr0_en,
    input  logic [4:0]       wr0_idx,
    input  logic [7:0]       wr0_data,
    input  logic             wr1_en,
    input  logic [4:0]       wr1_idx,
    input  logic [7:0]       wr1_data,
    output logic [BUS_W-1:0] q
);

    for (genvar g = 0; g < NUM_BYTES; g++) begin : g_lane
        logic [7:0] lane;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lane <= '0;
            end else if (clear) begin
                lane <= '0;
            end else if (wr0_en && (wr0_idx == 5'(g))) begin
                lane <= wr0_data;
            end else if (wr1_en && (wr1_idx == 5'(g))) begin
                lane <= wr1_data;
            end
        end

        assign q[byte_lsb(g) +: 8] = lane;
    end

endmodule

// File: rtl/copro_issue_unit.sv
// Host-side initiator for the matrix coprocessor: assembles operands, issues
// an instruction with a held start, captures the result and serves it back.
//
//   state | meaning
//   IDLE  | accepting host commands
//   ARM   | EXEC accepted, waiting for coprocessor to be idle
//   ISSUE | start held high until coprocessor leaves idle
//   WAIT  | waiting for copro_ready, result captured on first ready
//   DRAIN | waiting for coprocessor to return to idle
module copro_issue_unit import copro_issue_unit_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_data,
    output logic [31:0]      resp_data,
    output logic             resp_valid,
    output logic             busy,
    output logic [BUS_W-1:0] matrix_a,
    output logic [BUS_W-1:0] matrix_b,
    output logic [5:0]       instruction,
    output logic             start,
    input  logic [BUS_W-1:0] matrix_result,
    input  logic             copro_ready,
    input  logic             copro_overflow,
    input  logic [2:0]       copro_state
);

    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, next_state;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              rdy_q;
    logic              done_q, ovf_q, tmo_q, err_q;
    logic [BUS_W-1:0]  result_q;
    logic [31:0]       resp_word;

    logic              accept;
    logic [2:0]        op;
    logic [4:0]        load_base;
    logic [4:0]        rd_base;
    logic              load_acc, load_ok, load_hi_ok;
    logic              exec_ok, exec_go, clear_all;
    logic              tmo_expired, capture, timeout_hit;
    logic              unused_cmd_bits;

    assign op              = cmd_data[31:29];
    assign load_base       = cmd_data[20:16];
    assign rd_base         = cmd_data[4:0];
    assign unused_cmd_bits = ^cmd_data[27:21];

    assign cmd_ready  = rdy_q && (state == ST_IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign load_acc   = accept && (op == CMD_LOAD);
    assign load_ok    = (load_base <= MAX_IDX);
    assign load_hi_ok = (load_base < MAX_IDX);
    assign exec_ok    = (cmd_data[4:2] != OP_INVALID);
    assign exec_go    = accept && (op == CMD_EXEC) && exec_ok;
    assign clear_all  = accept && (op == CMD_CLEAR);
    assign busy       = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_DRAIN);

    byte_lane_writer u_mat_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear_all),
        .wr0_en   (load_acc && load_ok && !cmd_data[28]),
        .wr0_idx  (load_base),
        .wr0_data (cmd_data[15:8]),
        .wr1_en   (load_acc && load_hi_ok && !cmd_data[28]),
        .wr1_idx  (load_base + 5'd1),
        .wr1_data (cmd_data[7:0]),
        .q        (matrix_a)
    );

    byte_lane_writer u_mat_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear_all),
        .wr0_en   (load_acc && load_ok && cmd_data[28]),
        .wr0_idx  (load_base),
        .wr0_data (cmd_data[15:8]),
        .wr1_en   (load_acc && load_hi_ok && cmd_data[28]),
        .wr1_idx  (load_base + 5'd1),
        .wr1_data (cmd_data[7:0]),
        .q        (matrix_b)
    );

    assign tmo_expired = (state != ST_IDLE) && (tmo_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            start <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            state <= next_state;
            start <= (next_state == ST_ISSUE);
            rdy_q <= 1'b1;
        end
    end

    // A same-cycle copro_ready beats the timeout in WAIT.
    always_comb begin
        next_state  = state;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (exec_go) next_state = ST_ARM;
            end
            ST_ARM: begin
                if (tmo_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = ST_IDLE;
                end else if (copro_state == COPRO_IDLE) begin
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (tmo_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = ST_IDLE;
                end else if (copro_state != COPRO_IDLE) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (copro_ready) begin
                    capture    = 1'b1;
                    next_state = ST_DRAIN;
                end else if (tmo_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (copro_state == COPRO_IDLE) begin
                    next_state = ST_IDLE;
                end else if (tmo_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_IDLE) begin
            tmo_cnt <= TMO_LOAD;
        end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    always_comb begin
        resp_word           = '0;
        resp_word[RSP_DONE] = done_q;
        resp_word[RSP_OVF]  = ovf_q;
        resp_word[RSP_TMO]  = tmo_q;
        resp_word[RSP_ERR]  = err_q;
        resp_word[23:16]    = bus_byte(result_q, {1'b0, rd_base});
        resp_word[15:8]     = bus_byte(result_q, {1'b0, rd_base} + 6'd1);
        resp_word[7:0]      = bus_byte(result_q, {1'b0, rd_base} + 6'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
            instruction <= '0;
            resp_data   <= '0;
            resp_valid  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            if (accept) begin
                case (op)
                    CMD_NOP: ;
                    CMD_LOAD: begin
                        if (!load_ok) err_q <= 1'b1;
                    end
                    CMD_EXEC: begin
                        if (exec_ok) begin
                            instruction <= cmd_data[5:0];
                            done_q      <= 1'b0;
                            ovf_q       <= 1'b0;
                            tmo_q       <= 1'b0;
                            err_q       <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    CMD_READ: begin
                        resp_data  <= resp_word;
                        resp_valid <= 1'b1;
                    end
                    CMD_CLEAR: begin
                        result_q    <= '0;
                        instruction <= '0;
                        done_q      <= 1'b0;
                        ovf_q       <= 1'b0;
                        tmo_q       <= 1'b0;
                        err_q       <= 1'b0;
                    end
                    default: err_q <= 1'b1;
                endcase
            end
            if (capture) begin
                result_q <= matrix_result;
                ovf_q    <= copro_overflow;
                done_q   <= 1'b1;
            end
            if (timeout_hit) begin
                tmo_q  <= 1'b1;
                done_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_copro_issue_unit.sv
// Self-checking bench for copro_issue_unit: a byte-array reference model of the
// host-visible state plus a scripted coprocessor driving the handshake.
module tb_copro_issue_unit;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  cmd_data;
    logic [31:0]  resp_data;
    logic         resp_valid;
    logic         busy;
    logic [199:0] matrix_a;
    logic [199:0] matrix_b;
    logic [5:0]   instruction;
    logic         start;
    logic [199:0] matrix_result;
    logic         copro_ready;
    logic         copro_overflow;
    logic [2:0]   copro_state;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int TMO = 4096;

    logic [7:0] ma   [25];
    logic [7:0] mb   [25];
    logic [7:0] mres [25];
    bit         m_done, m_ovf, m_tmo, m_err;
    logic [5:0] m_instr;

    copro_issue_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_data       (cmd_data),
        .resp_data      (resp_data),
        .resp_valid     (resp_valid),
        .busy           (busy),
        .matrix_a       (matrix_a),
        .matrix_b       (matrix_b),
        .instruction    (instruction),
        .start          (start),
        .matrix_result  (matrix_result),
        .copro_ready    (copro_ready),
        .copro_overflow (copro_overflow),
        .copro_state    (copro_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int i = 0; i < 25; i++) begin
            ma[i] = 8'h00; mb[i] = 8'h00; mres[i] = 8'h00;
        end
        m_done = 0; m_ovf = 0; m_tmo = 0; m_err = 0; m_instr = 6'd0;
    endfunction

    function automatic logic [199:0] pack(input int which);
        logic [199:0] p;
        logic [7:0]   v;
        p = '0;
        for (int i = 0; i < 25; i++) begin
            v = (which == 0) ? ma[i] : (which == 1) ? mb[i] : mres[i];
            p[199 - 8 * i -: 8] = v;
        end
        return p;
    endfunction

    function automatic logic [7:0] mbyte(input int idx);
        return (idx > 24) ? 8'h00 : mres[idx];
    endfunction

    function automatic logic [31:0] exp_resp(input int b);
        return {m_done, m_ovf, m_tmo, m_err, 4'b0000, mbyte(b), mbyte(b + 1), mbyte(b + 2)};
    endfunction

    function automatic logic [199:0] rand200();
        logic [223:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[199:0];
    endfunction

    function automatic void model_cmd(input logic [31:0] w);
        int b;
        case (w[31:29])
            3'b000: ;
            3'b001: begin
                b = int'(w[20:16]);
                if (b > 24) m_err = 1;
                else begin
                    if (w[28]) mb[b] = w[15:8]; else ma[b] = w[15:8];
                    if (b + 1 <= 24) begin
                        if (w[28]) mb[b + 1] = w[7:0]; else ma[b + 1] = w[7:0];
                    end
                end
            end
            3'b010: begin
                if (w[4:2] == 3'b111) m_err = 1;
                else begin
                    m_done = 0; m_ovf = 0; m_tmo = 0; m_err = 0; m_instr = w[5:0];
                end
            end
            3'b011: ;
            3'b100: begin
                for (int i = 0; i < 25; i++) begin
                    ma[i] = 8'h00; mb[i] = 8'h00; mres[i] = 8'h00;
                end
                m_done = 0; m_ovf = 0; m_tmo = 0; m_err = 0; m_instr = 6'd0;
            end
            default: m_err = 1;
        endcase
    endfunction

    // Presents one command word, waits (bounded) for acceptance, updates the model.
    task automatic drive_cmd(input logic [31:0] w);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_accept_wait: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_data  = w;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data  = $urandom;
        model_cmd(w);
    endtask

    task automatic do_read(input int b);
        logic [31:0] exp;
        drive_cmd({3'b011, 24'd0, 5'(b)});
        exp = exp_resp(b);
        n_tests++;
        if (resp_valid !== 1'b1 || resp_data !== exp) begin
            n_fail++;
            $display("FAIL read_b%0d: valid=%b data=%h required valid=1 data=%h", b, resp_valid, resp_data, exp);
        end
        @(posedge clk); #1;
        n_tests++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_valid_pulse: resp_valid=%b required 0", resp_valid);
        end
    endtask

    // Scripted coprocessor transaction: optional CLN hold in ARM, ISSUE for issue_cyc
    // cycles, ready after wait_cyc cycles in WAIT, then drain_cyc cycles of CLN.
    task automatic run_exec(input logic [5:0] op, input int arm_hold, input int issue_cyc,
                            input int wait_cyc, input int drain_cyc, input bit ovf,
                            input logic [199:0] res);
        copro_state = (arm_hold > 0) ? 3'b101 : 3'b000;
        drive_cmd({3'b010, 23'd0, op});
        n_tests++;
        if (start !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_state: start=%b busy=%b required 0 0", start, busy);
        end
        for (int k = 0; k < arm_hold; k++) begin
            @(posedge clk); #1;
            n_tests++;
            if (start !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL arm_hold_cln: start=%b busy=%b cmd_ready=%b required 0 0 0", start, busy, cmd_ready);
            end
        end
        copro_state = 3'b000;
        for (int k = 0; k < issue_cyc; k++) begin
            @(posedge clk); #1;
            n_tests++;
            if (start !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL issue_start: cycle %0d start=%b busy=%b required 1 1", k, start, busy);
            end
        end
        copro_state = 3'b001;
        @(posedge clk); #1;
        n_tests++;
        if (start !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_state: start=%b busy=%b required 0 1", start, busy);
        end
        repeat (wait_cyc) @(posedge clk);
        #1;
        copro_ready    = 1'b1;
        copro_overflow = ovf;
        matrix_result  = res;
        @(posedge clk); #1;
        copro_ready    = 1'b0;
        copro_overflow = 1'b0;
        copro_state    = 3'b101;
        matrix_result  = rand200();
        for (int i = 0; i < 25; i++) mres[i] = res[199 - 8 * i -: 8];
        m_done = 1;
        m_ovf  = ovf;
        n_tests++;
        if (busy !== 1'b1 || start !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_state: busy=%b start=%b cmd_ready=%b required 1 0 0", busy, start, cmd_ready);
        end
        repeat (drain_cyc) @(posedge clk);
        #1;
        copro_state = 3'b000;
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_idle: busy=%b cmd_ready=%b required 0 1", busy, cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (start !== 0 || busy !== 0 || cmd_ready !== 0 || resp_valid !== 0 || resp_data !== 0 ||
            matrix_a !== 0 || matrix_b !== 0 || instruction !== 0) begin
            n_fail++;
            $display("FAIL reset_values: start=%b busy=%b cmd_ready=%b resp=%h instr=%h required all zero",
                     start, busy, cmd_ready, resp_data, instruction);
        end
        rst_n = 1'b1;
        n_tests++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_at_release: cmd_ready=%b required 0", cmd_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_release: cmd_ready=%b required 1", cmd_ready);
        end
        do_read(0);
    endtask

    task automatic test_load_a();
        int b;
        for (int k = 0; k < 13; k++) begin
            b = 2 * k;
            drive_cmd({3'b001, 1'b0, 7'd0, 5'(b), 8'(b + 1), (b == 24) ? 8'h7F : 8'(b + 2)});
        end
        n_tests++;
        if (matrix_a !== pack(0) || matrix_b !== pack(1)) begin
            n_fail++;
            $display("FAIL load_a_full: a=%h required %h", matrix_a, pack(0));
        end
        n_tests++;
        if (matrix_a[199:192] !== 8'd1 || matrix_a[7:0] !== 8'd25) begin
            n_fail++;
            $display("FAIL load_a_ends: byte0=%h byte24=%h required 01 19", matrix_a[199:192], matrix_a[7:0]);
        end
    endtask

    task automatic test_exec_basic();
        logic [199:0] res;
        res = rand200();
        run_exec(6'b000011, 0, 20, 38, 3, 1'b0, res);
        n_tests++;
        if (instruction !== 6'b000011) begin
            n_fail++;
            $display("FAIL instruction_latch: instruction=%b required 000011", instruction);
        end
        do_read(0);
        n_tests++;
        if (resp_data !== {8'h80, res[199:176]}) begin
            n_fail++;
            $display("FAIL read_held: resp_data=%h required %h", resp_data, {8'h80, res[199:176]});
        end
        do_read(23);
    endtask

    task automatic test_overflow();
        run_exec(6'b000100, 0, 3, 5, 2, 1'b1, rand200());
        do_read(5);
        n_tests++;
        if (resp_data[30] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag: resp_data[30]=%b required 1", resp_data[30]);
        end
    endtask

    task automatic test_timeout();
        drive_cmd({3'b010, 23'd0, 6'b001000});
        repeat (TMO - 1) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b1 || start !== 1'b1) begin
            n_fail++;
            $display("FAIL before_timeout: busy=%b start=%b required 1 1", busy, start);
        end
        @(posedge clk); #1;
        m_tmo  = 1;
        m_done = 0;
        n_tests++;
        if (busy !== 1'b0 || start !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL at_timeout: busy=%b start=%b cmd_ready=%b required 0 0 1", busy, start, cmd_ready);
        end
        do_read(0);
    endtask

    task automatic test_cln_and_err();
        run_exec(6'b000111, 10, 2, 4, 1, 1'b0, rand200());
        drive_cmd({3'b001, 1'b0, 7'd0, 5'd30, 16'hABCD});
        n_tests++;
        if (matrix_a !== pack(0)) begin
            n_fail++;
            $display("FAIL load_b30_nowrite: a=%h required %h", matrix_a, pack(0));
        end
        do_read(1);
        drive_cmd({3'b010, 23'd0, 6'b011100});
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_tests++;
            if (busy !== 1'b0 || start !== 1'b0) begin
                n_fail++;
                $display("FAIL invalid_op_no_issue: busy=%b start=%b required 0 0", busy, start);
            end
        end
        do_read(2);
        run_exec(6'b100001, 0, 1, 0, 0, 1'b0, rand200());
        drive_cmd({3'b111, 29'd0});
        do_read(3);
        run_exec(6'b000010, 0, 1, 1, 0, 1'b1, rand200());
        drive_cmd({3'b101, 29'd0});
        do_read(24);
    endtask

    task automatic test_clear();
        drive_cmd({3'b100, 29'd0});
        n_tests++;
        if (matrix_a !== 0 || matrix_b !== 0 || instruction !== 0) begin
            n_fail++;
            $display("FAIL clear_regs: a=%h b=%h instr=%h required 0", matrix_a, matrix_b, instruction);
        end
        do_read(0);
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [5:0]  op;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 8; k++) begin
                w = $urandom;
                w[31:29] = 3'b001;
                drive_cmd(w);
                n_tests++;
                if (matrix_a !== pack(0) || matrix_b !== pack(1)) begin
                    n_fail++;
                    $display("FAIL rand_load: word=%h a=%h b=%h required a=%h b=%h",
                             w, matrix_a, matrix_b, pack(0), pack(1));
                end
            end
            op = 6'($urandom_range(0, 63));
            while (op[4:2] == 3'b111) op = 6'($urandom_range(0, 63));
            run_exec(op, $urandom_range(0, 3), $urandom_range(1, 8), $urandom_range(0, 10),
                     $urandom_range(0, 5), 1'($urandom_range(0, 1)), rand200());
            n_tests++;
            if (instruction !== m_instr) begin
                n_fail++;
                $display("FAIL rand_instr: instruction=%b required %b", instruction, m_instr);
            end
            w = $urandom;
            w[31:29] = 3'b001;
            w[20:16] = 5'($urandom_range(0, 24));
            drive_cmd(w);
            for (int k = 0; k < 3; k++) do_read($urandom_range(0, 31));
        end
    endtask

    task automatic test_reset_mid_wait();
        copro_state = 3'b000;
        drive_cmd({3'b010, 23'd0, 6'b000001});
        @(posedge clk); #1;
        copro_state = 3'b010;
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b1 || start !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait_reach: busy=%b start=%b required 1 0", busy, start);
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (start !== 0 || busy !== 0 || resp_data !== 0 || matrix_a !== 0 || matrix_b !== 0 ||
            cmd_ready !== 0 || instruction !== 0) begin
            n_fail++;
            $display("FAIL async_reset: start=%b busy=%b resp=%h a_nz=%b cmd_ready=%b required all zero",
                     start, busy, resp_data, |matrix_a, cmd_ready);
        end
        copro_state = 3'b000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL after_mid_reset: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
        end
        do_read(0);
    endtask

    initial begin
        rst_n          = 1'b0;
        cmd_valid      = 1'b0;
        cmd_data       = '0;
        matrix_result  = '0;
        copro_ready    = 1'b0;
        copro_overflow = 1'b0;
        copro_state    = 3'b000;
        model_reset();

        test_reset();
        test_load_a();
        test_exec_basic();
        test_overflow();
        test_timeout();
        test_cln_and_err();
        test_clear();
        test_random();
        test_reset_mid_wait();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
